game_sequencer: RTL and testbench

//  Round/timing controller for whack-a-mole. Sequences mole spawns and enforces a per-mole hit window.

---
 rtl/game_sequencer.sv | 176 +++++++++++++++++
 tb/tb_game_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Whack-a-mole round/timing controller: spawns moles, times each hit window,
// ramps difficulty with hits, runs the game timer and flags game end.
// Ports:
//   clk, rst (sync, active-high), tick (timebase enable),
//   start (level, edge-detected), hit/wrong (1-cycle pulses).
//   mole_req (new mole pulse), mole_active (window open), game_end,
//   hit_cnt, miss_cnt, level, window, time_left (all registered).
module game_sequencer #(
  parameter int GAME_TICKS     = 600,
  parameter int WIN_INIT       = 16,
  parameter int WIN_MIN        = 4,
  parameter int WIN_STEP       = 2,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_MISSES     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        hit,
  input  logic        wrong,
  output logic        mole_req,
  output logic        mole_active,
  output logic        game_end,
  output logic [7:0]  hit_cnt,
  output logic [7:0]  miss_cnt,
  output logic [2:0]  level,
  output logic [7:0]  window,
  output logic [15:0] time_left
);

  typedef enum logic [1:0] {
    S_IDLE, S_SPAWN, S_WAIT, S_OVER
  } state_t;

  localparam logic [15:0] TIME_INIT = 16'(GAME_TICKS);
  localparam logic [7:0]  WIN_INI8  = 8'(WIN_INIT);
  localparam logic [7:0]  WIN_MIN8  = 8'(WIN_MIN);
  localparam logic [7:0]  WIN_STP8  = 8'(WIN_STEP);
  localparam logic [7:0]  HPL8      = 8'(HITS_PER_LEVEL);
  localparam logic [7:0]  MAXM8     = 8'(MAX_MISSES);

  state_t      state_q, state_d;
  logic        start_q;
  logic        req_q, req_d;
  logic        act_q, act_d;
  logic        end_q, end_d;
  logic [7:0]  hit_q, hit_d;
  logic [7:0]  miss_q, miss_d;
  logic [2:0]  lvl_q, lvl_d;
  logic [7:0]  win_q, win_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] time_q, time_d;

  logic        start_rise;
  logic        over;
  logic [1:0]  miss_inc;
  logic [7:0]  hit_new;

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [1:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    lvl_d    = lvl_q;
    win_d    = win_q;
    wcnt_d   = wcnt_q;
    time_d   = time_q;
    over     = 1'b0;
    miss_inc = 2'd0;
    hit_new  = 8'd0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          hit_d   = 8'd0;
          miss_d  = 8'd0;
          lvl_d   = 3'd0;
          win_d   = WIN_INI8;
          time_d  = TIME_INIT;
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        wcnt_d  = win_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit) begin
          hit_new = sat_add(hit_q, 2'd1);
          hit_d   = hit_new;
          state_d = S_SPAWN;
          if ((hit_new % HPL8) == 8'd0) begin
            lvl_d = (lvl_q == 3'd7) ? 3'd7 : lvl_q + 3'd1;
            // Clamp at the floor without letting the subtraction wrap.
            if ({1'b0, win_q} >= {1'b0, WIN_MIN8} + {1'b0, WIN_STP8})
              win_d = win_q - WIN_STP8;
            else
              win_d = WIN_MIN8;
          end
        end else begin
          if (tick && wcnt_q == 8'd1) begin
            miss_inc = 2'd1 + {1'b0, wrong};
            state_d  = S_SPAWN;
          end else begin
            if (tick) wcnt_d = wcnt_q - 8'd1;
            if (wrong) miss_inc = 2'd1;
          end
          miss_d = sat_add(miss_q, miss_inc);
          if (MAX_MISSES != 0 && miss_inc != 2'd0 && miss_d >= MAXM8)
            over = 1'b1;
        end
      end
    endcase

    if ((state_q == S_SPAWN || state_q == S_WAIT) && tick) begin
      if (time_q != 16'd0) time_d = time_q - 16'd1;
      if (time_q == 16'd1) over = 1'b1;
    end

    // Expiry and miss limit beat the normal flow but keep the counts above.
    if (over) state_d = S_OVER;

    req_d = (state_d == S_SPAWN);
    act_d = (state_d == S_WAIT);
    end_d = (state_d == S_IDLE) || (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      req_q   <= 1'b0;
      act_q   <= 1'b0;
      end_q   <= 1'b1;
      hit_q   <= 8'd0;
      miss_q  <= 8'd0;
      lvl_q   <= 3'd0;
      win_q   <= WIN_INI8;
      wcnt_q  <= 8'd0;
      time_q  <= TIME_INIT;
    end else begin
      state_q <= state_d;
      start_q <= start;
      req_q   <= req_d;
      act_q   <= act_d;
      end_q   <= end_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      lvl_q   <= lvl_d;
      win_q   <= win_d;
      wcnt_q  <= wcnt_d;
      time_q  <= time_d;
    end
  end

  assign mole_req    = req_q;
  assign mole_active = act_q;
  assign game_end    = end_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign level       = lvl_q;
  assign window      = win_q;
  assign time_left   = time_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_game_sequencer;

  localparam int GT   = 600;
  localparam int WI   = 16;
  localparam int WMIN = 4;
  localparam int WST  = 2;
  localparam int HPL  = 4;
  localparam int MAXM = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic hit = 1'b0;
  logic wrong = 1'b0;

  logic        mole_req, mole_active, game_end;
  logic [7:0]  hit_cnt, miss_cnt, window;
  logic [2:0]  level;
  logic [15:0] time_left;

  logic        s_req, s_act, s_end;
  logic [7:0]  s_hit, s_miss, s_win;
  logic [2:0]  s_lvl;
  logic [15:0] s_time;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  game_sequencer u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .hit(hit), .wrong(wrong),
    .mole_req(mole_req), .mole_active(mole_active),
    .game_end(game_end), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .level(level),
    .window(window), .time_left(time_left)
  );

  game_sequencer #(.GAME_TICKS(5)) u_short (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .hit(hit), .wrong(wrong),
    .mole_req(s_req), .mole_active(s_act),
    .game_end(s_end), .hit_cnt(s_hit),
    .miss_cnt(s_miss), .level(s_lvl),
    .window(s_win), .time_left(s_time)
  );

  typedef struct {
    logic rst, st, tk, ht, wr;
    logic req, act, ge;
    logic [7:0] h, m;
    logic [2:0] lv;
    logic [7:0] w;
    logic [15:0] t;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [63:0] pack(
    input logic rq, ac, ge,
    input logic [7:0] h, m,
    input logic [2:0] lv,
    input logic [7:0] w,
    input logic [15:0] t
  );
    return {18'd0, rq, ac, ge, h, m, lv, w, t};
  endfunction

  function automatic logic [63:0] outs();
    return pack(mole_req, mole_active, game_end, hit_cnt,
                miss_cnt, level, window, time_left);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input logic st, tk, ht, wr);
    start = st; tick = tk; hit = ht; wrong = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Behavioural model: a game is either off or running; while running
  // a mole is either about to be shown or has a number of ticks left.
  bit m_run, m_spawn, m_prev;
  int m_left, m_h, m_m, m_lv, m_w, m_t;

  task automatic m_reset();
    m_run = 0; m_spawn = 0; m_prev = 0; m_left = 0;
    m_h = 0; m_m = 0; m_lv = 0; m_w = WI; m_t = GT;
  endtask

  task automatic m_step(input bit r, st, tk, ht, wr);
    bit rise, fin;
    int add;
    if (r) begin m_reset(); return; end
    rise = st && !m_prev;
    m_prev = st;
    if (!m_run) begin
      if (rise) begin
        m_h = 0; m_m = 0; m_lv = 0; m_w = WI; m_t = GT;
        m_run = 1; m_spawn = 1;
      end
      return;
    end
    fin = 0;
    if (m_spawn) begin
      m_left = m_w; m_spawn = 0;
    end else if (ht) begin
      m_h = (m_h < 255) ? m_h + 1 : 255;
      if (m_h % HPL == 0) begin
        m_lv = (m_lv < 7) ? m_lv + 1 : 7;
        m_w = (m_w - WST < WMIN) ? WMIN : m_w - WST;
      end
      m_spawn = 1;
    end else begin
      add = 0;
      if (tk) begin
        if (m_left == 1) begin add++; m_spawn = 1; end
        else m_left--;
      end
      if (wr) add++;
      m_m = (m_m + add > 255) ? 255 : m_m + add;
      if (add > 0 && MAXM != 0 && m_m >= MAXM) fin = 1;
    end
    if (tk) begin
      if (m_t == 1) fin = 1;
      if (m_t > 0) m_t--;
    end
    if (fin) begin m_run = 0; m_spawn = 0; end
  endtask

  function automatic logic [63:0] m_out();
    return pack(m_run && m_spawn, m_run && !m_spawn, !m_run,
                8'(m_h), 8'(m_m), 3'(m_lv), 8'(m_w), 16'(m_t));
  endfunction

  initial begin
    tbl[0] = '{1,0,0,0,0, 0,0,1, 0,0,0,16,600};
    tbl[1] = '{0,0,0,0,0, 0,0,1, 0,0,0,16,600};
    tbl[2] = '{0,1,0,0,0, 1,0,0, 0,0,0,16,600};
    tbl[3] = '{0,1,0,0,0, 0,1,0, 0,0,0,16,600};
    tbl[4] = '{0,1,0,1,1, 1,0,0, 1,0,0,16,600};
    tbl[5] = '{0,0,0,0,0, 0,1,0, 1,0,0,16,600};
    tbl[6] = '{0,0,0,0,1, 0,1,0, 1,1,0,16,600};
    tbl[7] = '{0,0,1,0,0, 0,1,0, 1,1,0,16,599};
    tbl[8] = '{0,1,0,0,0, 0,1,0, 1,1,0,16,599};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      cyc(tbl[i].st, tbl[i].tk, tbl[i].ht, tbl[i].wr);
      chk($sformatf("vec%0d", i), outs(),
          pack(tbl[i].req, tbl[i].act, tbl[i].ge, tbl[i].h,
               tbl[i].m, tbl[i].lv, tbl[i].w, tbl[i].t));
    end
    rst = 1'b0;

    // Timeouts up to the miss limit
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (15) cyc(0, 1, 0, 0);
    chk("t2_pre_miss", {miss_cnt, 7'd0, mole_active}, {8'd0, 7'd0, 1'b1});
    cyc(0, 1, 0, 0);
    chk("t2_timeout", {miss_cnt, 7'd0, mole_req}, {8'd1, 7'd0, 1'b1});
    for (int k = 2; k <= 8; k++) begin
      cyc(0, 0, 0, 0);
      repeat (16) cyc(0, 1, 0, 0);
    end
    chk("t2_over", outs(), pack(0, 0, 1, 0, 8, 0, 16, 16'(GT - 128)));

    // Difficulty ramp
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      cyc(0, 0, 1, 0);
      if (i == 4)
        chk("t3_lvl1", {5'd0, level, window}, {5'd0, 3'd1, 8'd14});
      if (i == 24)
        chk("t3_lvl6", {5'd0, level, window}, {5'd0, 3'd6, 8'd4});
      if (i == 32)
        chk("t3_sat", {hit_cnt, 5'd0, level, window},
            {8'd32, 5'd0, 3'd7, 8'd4});
      cyc(0, 0, 0, 0);
    end

    // Last-tick hit wins; timeout plus wrong counts twice
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (15) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("t4_hit_edge", outs(), pack(1, 0, 0, 1, 0, 0, 16, 16'(GT - 16)));
    cyc(0, 0, 0, 0);
    repeat (15) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("t4_to_wrong", outs(), pack(1, 0, 0, 1, 2, 0, 16, 16'(GT - 32)));

    // Short game on the second instance
    do_reset();
    cyc(1, 0, 0, 0);
    chk("t5_spawn", {s_req, s_end, s_time}, {1'b1, 1'b0, 16'd5});
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (4) cyc(1, 1, 0, 0);
    chk("t5_over", {s_end, s_act, s_miss, s_time},
        {1'b1, 1'b0, 8'd1, 16'd0});
    repeat (3) cyc(1, 0, 0, 0);
    chk("t5_hold", {s_end, s_req, s_miss, s_time},
        {1'b1, 1'b0, 8'd1, 16'd0});
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t5_restart", {s_end, s_req, s_miss, s_time},
        {1'b0, 1'b1, 8'd0, 16'd5});

    // Reset in the middle of a game
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (4) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("t6_pre", outs(), pack(0, 1, 0, 4, 1, 1, 14, 16'(GT - 1)));
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("t6_reset", outs(), pack(0, 0, 1, 0, 0, 0, 16, 16'(GT)));

    // Randomized run against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      logic r, st, tk, ht, wr;
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 19) == 0) ? ~start : start;
      tk = ($urandom_range(0, 2) == 0);
      ht = ($urandom_range(0, 5) == 0);
      wr = !tk && ($urandom_range(0, 9) == 0);
      rst = r;
      m_step(r, st, tk, ht, wr);
      cyc(st, tk, ht, wr);
      chk($sformatf("rand%0d", c), outs(), m_out());
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
